fft_spectrum_framer: RTL and testbench

FFT_SPECTRUM_FRAMER -- requirements
Module: fft_spectrum_framer

---
 rtl/fft_frm_pkg.sv | 17 +
 rtl/fft_mag_approx.sv | 59 +++++
 rtl/fft_spectrum_framer.sv | 164 ++++++++++++++++
 tb/tb_fft_spectrum_framer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frm_pkg.sv
// Shared definitions for the FFT spectrum framer.
// Holds the framer state type and the default geometry of a spectrum frame
// (bins per frame, input component width, output magnitude width).
package fft_frm_pkg;

    localparam int unsigned N_BINS_DEF = 256;
    localparam int unsigned IN_W_DEF   = 16;
    localparam int unsigned OUT_W_DEF  = 32;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        RUN,
        DROP
    } frm_state_t;

endpackage

// File: rtl/fft_mag_approx.sv
// Two-stage alpha-max-plus-beta-min magnitude estimator.
//   stage 1: saturating |re|, |im|, sort into max/min
//   stage 2: mag = max + min/4 + min/8 at IN_W+1 bits
// Ports:
//   clk50M, rst_n        clock, synchronous active-low reset
//   stage1_en, stage2_en load enables; a stage holds its value when idle
//   s_re, s_im           signed FFT bin components
//   mag                  unsigned magnitude estimate, IN_W+1 bits
module fft_mag_approx
    import fft_frm_pkg::*;
#(
    parameter int unsigned IN_W = IN_W_DEF
) (
    input  logic                   clk50M,
    input  logic                   rst_n,
    input  logic                   stage1_en,
    input  logic                   stage2_en,
    input  logic signed [IN_W-1:0] s_re,
    input  logic signed [IN_W-1:0] s_im,
    output logic        [IN_W:0]   mag
);

    // Most negative input has no positive counterpart, so it clamps to the
    // largest positive value and every abs fits in IN_W-1 bits.
    function automatic logic [IN_W-2:0] sat_abs(input logic signed [IN_W-1:0] x);
        logic [IN_W-1:0] neg;
        neg = -x;
        if (!x[IN_W-1])
            return x[IN_W-2:0];
        else if (x[IN_W-2:0] == '0)
            return '1;
        else
            return neg[IN_W-2:0];
    endfunction

    logic [IN_W-2:0] a, b;
    logic [IN_W-2:0] mx_q, mn_q;

    always_comb begin
        a = sat_abs(s_re);
        b = sat_abs(s_im);
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            mx_q <= '0;
            mn_q <= '0;
            mag  <= '0;
        end else begin
            if (stage1_en) begin
                mx_q <= (a >= b) ? a : b;
                mn_q <= (a >= b) ? b : a;
            end
            if (stage2_en)
                mag <= {2'b00, mx_q} + {2'b00, mn_q >> 2} + {2'b00, mn_q >> 3};
        end
    end

endmodule

// File: rtl/fft_spectrum_framer.sv
// Frames a stream of FFT bins into fixed-length magnitude spectra.
// Checks every input frame against N_BINS, flags short/long frames, honours
// a display freeze at frame boundaries and counts completed output frames.
// Ports:
//   clk50M, rst_n             clock, synchronous active-low reset
//   s_re, s_im                signed FFT bin components
//   s_valid, s_last           bin strobe and end-of-input-frame marker
//   freeze                    hold: no new output frame starts while high
//   fft_data                  zero-extended magnitude, 2 cycles after input
//   fft_valid, fft_sop, fft_eop  output strobe and frame delimiters
//   frame_err                 pulse with the eop of a mis-sized frame
//   frame_cnt                 completed output frames (wraps)
module fft_spectrum_framer
    import fft_frm_pkg::*;
#(
    parameter int unsigned N_BINS = N_BINS_DEF,
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF
) (
    input  logic                   clk50M,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] s_re,
    input  logic signed [IN_W-1:0] s_im,
    input  logic                   s_valid,
    input  logic                   s_last,
    input  logic                   freeze,
    output logic [OUT_W-1:0]       fft_data,
    output logic                   fft_valid,
    output logic                   fft_sop,
    output logic                   fft_eop,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    localparam logic [15:0] LAST_BIN = 16'(N_BINS - 1);

    frm_state_t  state, state_nxt;
    logic [15:0] bin_cnt, bin_cnt_nxt;

    logic emit, sop, eop, err, cnt_inc;
    logic v1, sop1, eop1, err1, inc1;
    logic [IN_W:0] mag;

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            state   <= SYNC;
            bin_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bin_cnt <= bin_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bin_cnt_nxt = bin_cnt;
        if (s_valid) begin
            case (state)
                SYNC: if (s_last) state_nxt = IDLE;
                IDLE: begin
                    // A frozen single-bin frame is already over, so there is
                    // nothing to drop and the framer stays ready.
                    if (freeze) begin
                        if (!s_last) state_nxt = DROP;
                    end else if (!s_last) begin
                        state_nxt   = RUN;
                        bin_cnt_nxt = 16'd1;
                    end
                end
                RUN: begin
                    if (bin_cnt == LAST_BIN) begin
                        state_nxt   = s_last ? IDLE : SYNC;
                        bin_cnt_nxt = '0;
                    end else if (s_last) begin
                        state_nxt   = IDLE;
                        bin_cnt_nxt = '0;
                    end else begin
                        bin_cnt_nxt = bin_cnt + 16'd1;
                    end
                end
                DROP: if (s_last) state_nxt = IDLE;
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        emit    = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        err     = 1'b0;
        cnt_inc = 1'b0;
        if (s_valid) begin
            case (state)
                IDLE: begin
                    if (!freeze) begin
                        emit = 1'b1;
                        sop  = 1'b1;
                        eop  = s_last;
                        err  = s_last;
                    end
                end
                RUN: begin
                    emit = 1'b1;
                    if (bin_cnt == LAST_BIN) begin
                        eop     = 1'b1;
                        err     = !s_last;
                        cnt_inc = 1'b1;
                    end else if (s_last) begin
                        eop = 1'b1;
                        err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Flags ride alongside the two magnitude stages so they line up with
    // fft_data; frame_cnt updates on the same edge that outputs the eop.
    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            sop1      <= 1'b0;
            eop1      <= 1'b0;
            err1      <= 1'b0;
            inc1      <= 1'b0;
            fft_valid <= 1'b0;
            fft_sop   <= 1'b0;
            fft_eop   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            v1        <= emit;
            sop1      <= sop;
            eop1      <= eop;
            err1      <= err;
            inc1      <= cnt_inc;
            fft_valid <= v1;
            fft_sop   <= sop1;
            fft_eop   <= eop1;
            frame_err <= err1;
            if (inc1) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    fft_mag_approx #(
        .IN_W(IN_W)
    ) u_mag (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .stage1_en(emit),
        .stage2_en(v1),
        .s_re     (s_re),
        .s_im     (s_im),
        .mag      (mag)
    );

    always_comb begin
        fft_data         = '0;
        fft_data[IN_W:0] = mag;
    end

endmodule

// File: tb/tb_fft_spectrum_framer.sv
// Self-checking bench for fft_spectrum_framer: directed frames drive a
// frame-level behavioural model that predicts every output cycle.
module tb_fft_spectrum_framer;

    localparam int N  = 256;
    localparam int IW = 16;
    localparam int OW = 32;

    logic          clk50M  = 1'b0;
    logic          rst_n   = 1'b0;
    logic [IW-1:0] s_re    = '0;
    logic [IW-1:0] s_im    = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          freeze  = 1'b0;
    logic [OW-1:0] fft_data;
    logic          fft_valid, fft_sop, fft_eop, frame_err;
    logic [15:0]   frame_cnt;

    fft_spectrum_framer #(
        .N_BINS(N),
        .IN_W  (IW),
        .OUT_W (OW)
    ) dut (
        .clk50M   (clk50M),
        .rst_n    (rst_n),
        .s_re     (s_re),
        .s_im     (s_im),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .freeze   (freeze),
        .fft_data (fft_data),
        .fft_valid(fft_valid),
        .fft_sop  (fft_sop),
        .fft_eop  (fft_eop),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #10 clk50M = ~clk50M;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    always @(posedge clk50M) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int t;
        int data;
        bit sop;
        bit eop;
        bit err;
        int cnt;
    } exp_t;

    typedef enum int {M_WAIT, M_READY, M_OUT, M_SKIP} mode_t;

    exp_t  q[$];
    mode_t mode = M_WAIT;
    int    pos  = 0;
    int    mcnt = 0;

    function automatic int model_mag(input int re, input int im);
        int a, b, mx, mn;
        int lim = (1 << (IW - 1)) - 1;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        if (a > lim) a = lim;
        if (b > lim) b = lim;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic push(input int d, input bit sop, input bit eop, input bit err);
        exp_t x;
        x.t = cyc + 2; x.data = d; x.sop = sop; x.eop = eop; x.err = err; x.cnt = mcnt;
        q.push_back(x);
    endtask

    task automatic drive_bin(input int re, input int im, input bit last, input bit fz);
        int d;
        @(posedge clk50M); #1;
        s_valid = 1'b1;
        s_re    = re[IW-1:0];
        s_im    = im[IW-1:0];
        s_last  = last;
        freeze  = fz;
        d = model_mag(re, im);
        case (mode)
            M_WAIT:  if (last) mode = M_READY;
            M_READY: begin
                if (fz) begin
                    if (!last) mode = M_SKIP;
                end else begin
                    push(d, 1'b1, last, last);
                    if (!last) begin pos = 1; mode = M_OUT; end
                end
            end
            M_OUT: begin
                if (pos == N - 1) begin
                    mcnt = (mcnt + 1) % 65536;
                    push(d, 1'b0, 1'b1, !last);
                    mode = last ? M_READY : M_WAIT;
                end else if (last) begin
                    push(d, 1'b0, 1'b1, 1'b1);
                    mode = M_READY;
                end else begin
                    push(d, 1'b0, 1'b0, 1'b0);
                    pos++;
                end
            end
            M_SKIP:  if (last) mode = M_READY;
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk50M); #1;
            s_valid = 1'b0;
            s_last  = 1'b1;
            s_re    = 16'h1234;
            s_im    = 16'h8765;
        end
    endtask

    task automatic do_reset();
        exp_t keep[$];
        @(posedge clk50M); #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        foreach (q[i]) if (q[i].t <= cyc) keep.push_back(q[i]);
        q    = keep;
        mode = M_WAIT;
        pos  = 0;
        mcnt = 0;
        @(posedge clk50M); #1;
        rst_n = 1'b1;
    endtask

    function automatic int pat_re(input int pat, input int i);
        if (pat == 0) return 800;
        return (((i * 37 + pat * 101) % 4001) - 2000) * 8;
    endfunction

    function automatic int pat_im(input int pat, input int i);
        if (pat == 0) return -600;
        return (((i * 53 + pat * 29) % 3001) - 1500) * 8;
    endfunction

    task automatic send_frame(input int nbins, input int last_at, input int pat, input int gap,
                              input int fz_from, input int fz_to, input int rst_at);
        for (int i = 0; i < nbins; i++) begin
            if (i == rst_at) do_reset();
            if (gap > 0 && i > 0 && (i % gap) == 0) idle(1);
            drive_bin(pat_re(pat, i), pat_im(pat, i), i == last_at, (i >= fz_from) && (i < fz_to));
        end
    endtask

    // ---------------- compare process ----------------
    exp_t e;
    int   exp_cnt   = 0;
    int   last_data = 0;

    always @(negedge clk50M) begin
        if (cyc >= 1) begin
            if (!rst_q) begin
                check("rst_valid", fft_valid, 0);
                check("rst_sop",   fft_sop,   0);
                check("rst_eop",   fft_eop,   0);
                check("rst_err",   frame_err, 0);
                check("rst_data",  fft_data,  0);
                check("rst_cnt",   frame_cnt, 0);
                exp_cnt   = 0;
                last_data = 0;
            end else if (q.size() != 0 && q[0].t == cyc) begin
                e = q.pop_front();
                n_valid++;
                check("valid",     fft_valid, 1);
                check("data",      fft_data,  e.data);
                check("sop",       fft_sop,   e.sop);
                check("eop",       fft_eop,   e.eop);
                check("frame_err", frame_err, e.err);
                check("frame_cnt", frame_cnt, e.cnt);
                exp_cnt   = e.cnt;
                last_data = e.data;
            end else begin
                check("idle_valid", fft_valid, 0);
                check("idle_sop",   fft_sop,   0);
                check("idle_eop",   fft_eop,   0);
                check("idle_err",   frame_err, 0);
                check("idle_cnt",   frame_cnt, exp_cnt);
                check("hold_data",  fft_data,  last_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d assertions evaluated", n_chk);
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int v0;

        check("pin_mag_800_600", model_mag(800, -600), 1025);
        check("pin_mag_sat",     model_mag(-32768, 0), 32767);
        check("pin_mag_3_4",     model_mag(3, -4), 4);
        check("pin_mag_both",    model_mag(-32768, -32768), 45053);

        repeat (3) @(posedge clk50M);
        #1 rst_n = 1'b1;
        idle(2);

        // frame 0 arrives while synchronising: discarded
        v0 = n_valid;
        send_frame(N, N - 1, 2, 0, -1, -1, -1);
        idle(4);
        check("sync_discard_bins", n_valid - v0, 0);

        // frame 1: constant bins, with input gaps
        v0 = n_valid;
        send_frame(N, N - 1, 0, 50, -1, -1, -1);
        idle(4);
        check("f1_bins", n_valid - v0, N);
        check("f1_frame_cnt", frame_cnt, 1);

        // saturation and small values, with an exact latency check
        idle(3);
        drive_bin(-32768, 0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk50M); check("lat_not_early", fft_valid, 0);
        @(negedge clk50M); check("lat_valid", fft_valid, 1);
        check("lat_sat_data", fft_data, 32767);
        drive_bin(3, -4, 1'b0, 1'b0);
        idle(1);
        @(negedge clk50M);
        @(negedge clk50M); check("small_valid", fft_valid, 1);
        check("small_data", fft_data, 4);
        drive_bin(0, -32768, 1'b0, 1'b0);
        drive_bin(-32768, -32768, 1'b0, 1'b0);
        for (int i = 4; i < N; i++) drive_bin(pat_re(1, i), pat_im(1, i), i == N - 1, 1'b0);
        idle(4);
        check("f2_frame_cnt", frame_cnt, 2);

        // frozen at frame start: whole frame dropped
        v0 = n_valid;
        send_frame(N, N - 1, 5, 0, 0, 10, -1);
        idle(4);
        check("freeze_drop_bins", n_valid - v0, 0);
        check("freeze_frame_cnt", frame_cnt, 2);
        send_frame(N, N - 1, 6, 0, -1, -1, -1);
        idle(4);
        check("after_freeze_cnt", frame_cnt, 3);

        // short frame: s_last on bin 99
        v0 = n_valid;
        send_frame(100, 99, 7, 0, -1, -1, -1);
        idle(4);
        check("short_bins", n_valid - v0, 100);
        check("short_frame_cnt", frame_cnt, 3);
        // freeze asserted mid-frame is ignored
        send_frame(N, N - 1, 8, 0, 50, 100, -1);
        idle(4);
        check("midfreeze_cnt", frame_cnt, 4);

        // long frame: no s_last until bin 299
        v0 = n_valid;
        send_frame(300, 299, 9, 0, -1, -1, -1);
        idle(4);
        check("long_bins", n_valid - v0, N);
        check("long_frame_cnt", frame_cnt, 5);
        send_frame(N, N - 1, 10, 0, -1, -1, -1);
        idle(4);
        check("after_long_cnt", frame_cnt, 6);

        // single-bin frame straight from idle
        send_frame(1, 0, 11, 0, -1, -1, -1);
        idle(4);
        check("single_frame_cnt", frame_cnt, 6);

        // reset mid-frame at bin 128, input with gaps; rest of frame discarded
        send_frame(N, N - 1, 12, 20, -1, -1, 128);
        idle(4);
        check("post_reset_cnt", frame_cnt, 0);
        v0 = n_valid;
        send_frame(N, N - 1, 13, 0, -1, -1, -1);
        idle(4);
        check("resync_bins", n_valid - v0, N);
        check("resync_frame_cnt", frame_cnt, 1);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
